// File: rtl/mmi_pkg.sv
// Shared definitions for the MMI control bank: register map offsets, STATUS bit
// positions and the command entry carried through the command FIFO.
package mmi_pkg;

    localparam int unsigned OFS_DATA  = 0;
    localparam int unsigned OFS_CMD   = 4;
    localparam int unsigned OFS_ADDR  = 8;
    localparam int unsigned OFS_DEST  = 12;
    localparam int unsigned STRIDE    = 16;

    localparam int unsigned STS_EMPTY   = 0;
    localparam int unsigned STS_FULL    = 1;
    localparam int unsigned STS_OVF     = 2;
    localparam int unsigned STS_CNT_LSB = 8;
    localparam int unsigned STS_CNT_W   = 5;

    localparam int unsigned CH_W = 3;

    typedef struct packed {
        logic [CH_W-1:0] ch;
        logic [7:0]      cmd;
        logic [7:0]      data;
        logic [15:0]     addr_th;
        logic [15:0]     addr_src;
        logic [15:0]     addr_dest;
    } cmd_entry_t;

    localparam int unsigned ENTRY_W = $bits(cmd_entry_t);

    // Word index of a register inside its channel block.
    function automatic logic [1:0] reg_word(input int unsigned ofs);
        return 2'(ofs / 4);
    endfunction

endpackage

// File: rtl/mmi_ctrl_bank_if.sv
// CPU store/load port and peripheral command handshake of the MMI control bank.
interface mmi_ctrl_bank_if;

    logic        valid;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] i_data;
    logic [31:0] o_rdata;

    logic        o_valid;
    logic        i_ready;
    logic [2:0]  o_ch;
    logic [7:0]  o_command;
    logic [7:0]  o_data;
    logic [15:0] o_addr_th;
    logic [15:0] o_addr_src;
    logic [15:0] o_addr_dest;
    logic        o_overflow;

    modport master (
        output valid, wen, addr, i_data, i_ready,
        input  o_rdata, o_valid, o_ch, o_command, o_data,
               o_addr_th, o_addr_src, o_addr_dest, o_overflow
    );

    modport slave (
        input  valid, wen, addr, i_data, i_ready,
        output o_rdata, o_valid, o_ch, o_command, o_data,
               o_addr_th, o_addr_src, o_addr_dest, o_overflow
    );

endinterface

// File: rtl/mmi_cmd_fifo.sv
// Show-ahead command FIFO with registered head outputs; the head register is loaded
// with whatever entry will be at the front after this cycle's pop/push.
module mmi_cmd_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic                   head_valid,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full_c,
    output logic                   empty_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    logic             pop_ok_c;
    logic             push_ok_c;
    logic [PTR_W-1:0] rd_next_c;
    logic [CNT_W-1:0] kept_c;
    logic [CNT_W-1:0] cnt_next_c;
    logic [WIDTH-1:0] head_next_c;

    assign full_c  = (count == CNT_W'(DEPTH));
    assign empty_c = (count == '0);

    // A push on a full FIFO is only taken when the head leaves in the same cycle.
    always_comb begin
        pop_ok_c    = pop && head_valid;
        push_ok_c   = push && (!full_c || pop_ok_c);
        rd_next_c   = rd_ptr + PTR_W'(pop_ok_c);
        kept_c      = count - CNT_W'(pop_ok_c);
        cnt_next_c  = kept_c + CNT_W'(push_ok_c);
        head_next_c = '0;
        if (cnt_next_c == '0) begin
            head_next_c = '0;
        end else if (kept_c == '0) begin
            head_next_c = push_data;
        end else begin
            head_next_c = mem[rd_next_c];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else begin
            rd_ptr     <= rd_next_c;
            count      <= cnt_next_c;
            head_valid <= (cnt_next_c != '0);
            head_data  <= head_next_c;
            if (push_ok_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/mmi_ctrl_bank.sv
// Memory-mapped MMI control bank: per-channel DATA/CMD/ADDR/DEST registers, CMD-triggered
// command snapshots into mmi_cmd_fifo, STATUS with W1C overflow. MMI_READBACK_EN enables readback.
module mmi_ctrl_bank
    import mmi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0014,
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    mmi_ctrl_bank_if.slave  bus
);

    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SPAN_W = NUM_CH * STRIDE / 4;
    localparam logic [1:0]  W_DATA = reg_word(OFS_DATA);
    localparam logic [1:0]  W_CMD  = reg_word(OFS_CMD);
    localparam logic [1:0]  W_ADDR = reg_word(OFS_ADDR);
    localparam logic [1:0]  W_DEST = reg_word(OFS_DEST);

    logic [7:0]  data_q [NUM_CH];
    logic [15:0] th_q   [NUM_CH];
    logic [15:0] src_q  [NUM_CH];
    logic [15:0] dest_q [NUM_CH];
`ifdef MMI_READBACK_EN
    logic [7:0]  cmd_q  [NUM_CH];
`endif

    logic [29:0]      off_c;
    logic             in_ch_c;
    logic             is_status_c;
    logic [CH_W-1:0]  sel_ch_c;
    logic [1:0]       sel_reg_c;
    logic             wr_c;
    logic             rd_c;
    logic             cmd_push_c;
    logic             pop_c;
    logic             drop_c;
    logic             ovf_clr_c;
    cmd_entry_t       entry_c;
    cmd_entry_t       head;
    logic             head_valid;
    logic [CNT_W-1:0] count;
    logic             full_c;
    logic             empty_c;
    logic [31:0]      status_c;
    logic [31:0]      rdata_c;
    logic [31:0]      rdata_q;
    logic             ovf_q;
    logic             unused_c;

    assign unused_c = ^bus.addr[1:0];

    // Word-granular decode relative to the bank base; addresses below base wrap far out of range.
    always_comb begin
        off_c       = bus.addr[31:2] - BASE_ADDR[31:2];
        in_ch_c     = (off_c < 30'(SPAN_W));
        is_status_c = (off_c == 30'(SPAN_W));
        sel_ch_c    = off_c[4:2];
        sel_reg_c   = off_c[1:0];
        wr_c        = bus.valid && (bus.wen != 4'b0000);
        rd_c        = bus.valid && (bus.wen == 4'b0000);
        cmd_push_c  = wr_c && in_ch_c && (sel_reg_c == W_CMD) && bus.wen[0];
        pop_c       = head_valid && bus.i_ready;
        drop_c      = cmd_push_c && full_c && !pop_c;
        ovf_clr_c   = wr_c && is_status_c && bus.wen[0] && bus.i_data[STS_OVF];
    end

    // Snapshot uses register values held before this edge, so a same-cycle write is not seen.
    always_comb begin
        entry_c     = '0;
        entry_c.ch  = sel_ch_c;
        entry_c.cmd = bus.i_data[7:0];
        for (int c = 0; c < int'(NUM_CH); c++) begin
            if (sel_ch_c == CH_W'(c)) begin
                entry_c.data      = data_q[c];
                entry_c.addr_th   = th_q[c];
                entry_c.addr_src  = src_q[c];
                entry_c.addr_dest = dest_q[c];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < int'(NUM_CH); c++) begin
                data_q[c] <= '0;
                th_q[c]   <= '0;
                src_q[c]  <= '0;
                dest_q[c] <= '0;
`ifdef MMI_READBACK_EN
                cmd_q[c]  <= '0;
`endif
            end
        end else if (wr_c && in_ch_c) begin
            for (int c = 0; c < int'(NUM_CH); c++) begin
                if (sel_ch_c == CH_W'(c)) begin
                    case (sel_reg_c)
                        W_DATA: if (bus.wen[0]) data_q[c] <= bus.i_data[7:0];
                        W_CMD: begin
`ifdef MMI_READBACK_EN
                            if (bus.wen[0]) cmd_q[c] <= bus.i_data[7:0];
`endif
                        end
                        W_ADDR: begin
                            if (bus.wen[0]) th_q[c][7:0]   <= bus.i_data[7:0];
                            if (bus.wen[1]) th_q[c][15:8]  <= bus.i_data[15:8];
                            if (bus.wen[2]) src_q[c][7:0]  <= bus.i_data[23:16];
                            if (bus.wen[3]) src_q[c][15:8] <= bus.i_data[31:24];
                        end
                        W_DEST: begin
                            if (bus.wen[0]) dest_q[c][7:0]  <= bus.i_data[7:0];
                            if (bus.wen[1]) dest_q[c][15:8] <= bus.i_data[15:8];
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    mmi_cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (cmd_push_c),
        .push_data  (entry_c),
        .pop        (pop_c),
        .head_valid (head_valid),
        .head_data  (head),
        .count      (count),
        .full_c     (full_c),
        .empty_c    (empty_c)
    );

    always_comb begin
        status_c                                = '0;
        status_c[STS_EMPTY]                     = empty_c;
        status_c[STS_FULL]                      = full_c;
        status_c[STS_OVF]                       = ovf_q;
        status_c[STS_CNT_LSB +: STS_CNT_W]      = STS_CNT_W'(count);
    end

    always_comb begin
        rdata_c = '0;
        if (rd_c) begin
            if (is_status_c) begin
                rdata_c = status_c;
            end
`ifdef MMI_READBACK_EN
            else if (in_ch_c) begin
                for (int c = 0; c < int'(NUM_CH); c++) begin
                    if (sel_ch_c == CH_W'(c)) begin
                        case (sel_reg_c)
                            W_DATA:  rdata_c = {24'h0, data_q[c]};
                            W_CMD:   rdata_c = {24'h0, cmd_q[c]};
                            W_ADDR:  rdata_c = {src_q[c], th_q[c]};
                            W_DEST:  rdata_c = {16'h0, dest_q[c]};
                            default: rdata_c = '0;
                        endcase
                    end
                end
            end
`endif
        end
    end

    // A drop in the same cycle as a W1C leaves the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            rdata_q <= rdata_c;
            if (drop_c) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr_c) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign bus.o_rdata     = rdata_q;
    assign bus.o_overflow  = ovf_q;
    assign bus.o_valid     = head_valid;
    assign bus.o_ch        = head.ch;
    assign bus.o_command   = head.cmd;
    assign bus.o_data      = head.data;
    assign bus.o_addr_th   = head.addr_th;
    assign bus.o_addr_src  = head.addr_src;
    assign bus.o_addr_dest = head.addr_dest;

endmodule

// File: tb/tb_mmi_ctrl_bank.sv
// Bench for mmi_ctrl_bank: directed register-map scenarios then random bus traffic,
// checked against a queue-based model of the register map and command FIFO.
module tb_mmi_ctrl_bank;

    localparam logic [31:0] BASE  = 32'h0000_0014;
    localparam int          NCH   = 2;
    localparam int          DEPTH = 4;
    localparam logic [31:0] STS   = BASE + 32'(16 * NCH);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mmi_ctrl_bank_if bus ();

    mmi_ctrl_bank #(
        .BASE_ADDR  (BASE),
        .NUM_CH     (NCH),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0]  m_data [8];
    logic [7:0]  m_cmd  [8];
    logic [15:0] m_th   [8];
    logic [15:0] m_src  [8];
    logic [15:0] m_dest [8];
    logic [66:0] q [$];
    logic        m_ovf;
    logic [31:0] m_rdata;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [66:0] head_out();
        return {bus.o_ch, bus.o_command, bus.o_data, bus.o_addr_th, bus.o_addr_src, bus.o_addr_dest};
    endfunction

    function automatic logic [31:0] m_status();
        return {19'b0, 5'(q.size()), 5'b0, m_ovf, q.size() == DEPTH, q.size() == 0};
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 8; c++) begin
            m_data[c] = '0; m_cmd[c] = '0; m_th[c] = '0; m_src[c] = '0; m_dest[c] = '0;
        end
        q.delete();
        m_ovf   = 1'b0;
        m_rdata = '0;
    endtask

    // One bus cycle: drive, predict from pre-edge model state, clock, then compare.
    task automatic step(input logic v, input logic [3:0] w, input logic [31:0] a,
                        input logic [31:0] d, input logic rdy);
        logic [31:0] wa;
        int          c;
        int          r;
        bit          is_st;
        bit          pop;
        bit          push;
        logic [31:0] nrd;
        logic [66:0] entry;
        bus.valid = v; bus.wen = w; bus.addr = a; bus.i_data = d; bus.i_ready = rdy;
        wa = a & ~32'h3;
        c = -1; r = 0; entry = '0;
        if (wa >= BASE && wa < STS) begin
            c = int'((wa - BASE) / 16);
            r = int'(((wa - BASE) % 16) / 4);
        end
        is_st = (wa == STS);
        pop   = (q.size() > 0) && rdy;
        nrd   = '0;
        if (v && w == 4'b0000) begin
            if (is_st) nrd = m_status();
`ifdef MMI_READBACK_EN
            else if (c >= 0) begin
                case (r)
                    0: nrd = {24'h0, m_data[c]};
                    1: nrd = {24'h0, m_cmd[c]};
                    2: nrd = {m_src[c], m_th[c]};
                    default: nrd = {16'h0, m_dest[c]};
                endcase
            end
`endif
        end
        push = v && w[0] && (c >= 0) && (r == 1);
        if (push) entry = {3'(c), d[7:0], m_data[c], m_th[c], m_src[c], m_dest[c]};
        @(posedge clk);
        #1;
        if (pop) void'(q.pop_front());
        if (push && q.size() == DEPTH) m_ovf = 1'b1;
        else begin
            if (push) q.push_back(entry);
            if (v && w[0] && is_st && d[2]) m_ovf = 1'b0;
        end
        if (v && w != 4'b0000 && c >= 0) begin
            case (r)
                0: if (w[0]) m_data[c] = d[7:0];
                1: if (w[0]) m_cmd[c] = d[7:0];
                2: begin
                    if (w[0]) m_th[c][7:0]   = d[7:0];
                    if (w[1]) m_th[c][15:8]  = d[15:8];
                    if (w[2]) m_src[c][7:0]  = d[23:16];
                    if (w[3]) m_src[c][15:8] = d[31:24];
                end
                default: begin
                    if (w[0]) m_dest[c][7:0]  = d[7:0];
                    if (w[1]) m_dest[c][15:8] = d[15:8];
                end
            endcase
        end
        m_rdata = nrd;
        check("o_valid", bus.o_valid, q.size() != 0);
        if (q.size() != 0) check("head", head_out(), q[0]);
        check("o_overflow", bus.o_overflow, m_ovf);
        check("o_rdata", bus.o_rdata, m_rdata);
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 4'h0, 32'h0, 32'h0, rdy);
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  w;
        bus.valid = 1'b0; bus.wen = '0; bus.addr = '0; bus.i_data = '0; bus.i_ready = 1'b0;
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", bus.o_valid, 1'b0);
        check("rst_head", head_out(), 67'h0);
        check("rst_ovf", bus.o_overflow, 1'b0);
        check("rst_rdata", bus.o_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Channel 0 programming followed by a CMD store.
        step(1'b1, 4'h1, 32'h14, 32'h0000_00AB, 1'b0);
        step(1'b1, 4'hF, 32'h1C, 32'h2000_0100, 1'b0);
        step(1'b1, 4'hF, 32'h20, 32'h0000_0300, 1'b0);
        step(1'b1, 4'h1, 32'h18, 32'h0000_0005, 1'b0);
        check("t1_valid", bus.o_valid, 1'b1);
        check("t1_head", head_out(), {3'd0, 8'h05, 8'hAB, 16'h0100, 16'h2000, 16'h0300});

        // Partial-lane ADDR write touches only the threshold half.
        step(1'b1, 4'h3, 32'h1C, 32'hFFFF_1234, 1'b0);
        step(1'b1, 4'h0, 32'h1C, 32'h0, 1'b0);
`ifdef MMI_READBACK_EN
        check("t2_addr", bus.o_rdata, 32'h2000_1234);
`endif
        idle(1'b1);
        check("t2_drained", bus.o_valid, 1'b0);

        // Channel 1 CMD and a STATUS read.
        step(1'b1, 4'h1, 32'h28, 32'h0000_0077, 1'b0);
        check("t5_ch", bus.o_ch, 3'd1);
        step(1'b1, 4'h0, STS, 32'h0, 1'b0);
        check("t5_status", bus.o_rdata, 32'h0000_0100);
        idle(1'b1);

        // Overfill with the peripheral stalled, then drain in order.
        for (int i = 0; i < 5; i++) step(1'b1, 4'h1, 32'h18, 32'(8'h10 + i), 1'b0);
        step(1'b1, 4'h0, STS, 32'h0, 1'b0);
        check("t3_status", bus.o_rdata, 32'h0000_0406);
        check("t3_head_cmd", bus.o_command, 8'h10);
        for (int i = 0; i < 4; i++) idle(1'b1);
        check("t3_empty", bus.o_valid, 1'b0);
        step(1'b1, 4'h1, STS, 32'h0000_0004, 1'b0);
        step(1'b1, 4'h0, STS, 32'h0, 1'b0);
        check("t3_w1c", bus.o_rdata, 32'h0000_0001);

        // Push into a full FIFO while the head is popped.
        for (int i = 0; i < 4; i++) step(1'b1, 4'h1, 32'h18, 32'(8'h20 + i), 1'b0);
        step(1'b1, 4'h1, 32'h28, 32'h0000_0030, 1'b1);
        step(1'b1, 4'h0, STS, 32'h0, 1'b0);
        check("t4_status", bus.o_rdata, 32'h0000_0402);
        check("t4_ovf", bus.o_overflow, 1'b0);

        // Asynchronous reset with entries still queued.
        idle(1'b1);
        rst = 1'b1;
        #1;
        check("t6_valid", bus.o_valid, 1'b0);
        check("t6_head", head_out(), 67'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step(1'b1, 4'h0, STS, 32'h0, 1'b0);
        check("t6_status", bus.o_rdata, 32'h0000_0001);
        step(1'b1, 4'h1, 32'h28, 32'h0000_0042, 1'b0);
        check("t6_zero_regs", head_out(), {3'd1, 8'h42, 8'h00, 16'h0, 16'h0, 16'h0});
        idle(1'b1);

        // Random traffic across mapped, STATUS and unmapped addresses.
        for (int n = 0; n < 600; n++) begin
            case ($urandom % 8)
                0, 1, 2, 3, 4: a = BASE + 32'(16 * ($urandom % NCH)) + 32'(4 * ($urandom % 4)) + 32'($urandom % 4);
                5:             a = STS + 32'($urandom % 4);
                6:             a = STS + 32'h4 + 32'(4 * ($urandom % 8));
                default:       a = $urandom;
            endcase
            w = ($urandom % 3 == 0) ? 4'h0 : 4'($urandom);
            step(($urandom % 4) != 0, w, a, $urandom, ($urandom % 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
